// File: rtl/mem_arb_pkg.sv
// Shared types and width helpers for the two-requester memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DBG = 1'b1
  } owner_e;

  localparam int unsigned DEF_ADDR_WIDTH = 14;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  function automatic int unsigned be_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle for one requester of the shared memory port.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
  localparam int unsigned BE_WIDTH = be_width(DATA_WIDTH);

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [BE_WIDTH-1:0]   req_be;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;

  modport master (
    output req_valid, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/arb_resp_tracker.sv
// Tracks {valid, owner} of every accepted request through the memory latency
// and raises the owner's response strobe when the data comes back.
module arb_resp_tracker
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   accept,
  input  owner_e owner,
  output logic   cpu_resp_valid,
  output logic   dbg_resp_valid
);
  logic [MEM_LATENCY-1:0] vld;
  owner_e                 own [MEM_LATENCY];

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld <= '0;
      for (int unsigned i = 0; i < MEM_LATENCY; i++) own[i] <= OWNER_CPU;
    end else begin
      vld[0] <= accept;
      own[0] <= owner;
      for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        own[i] <= own[i-1];
      end
    end
  end

  // Gated by rst so a single-cycle-latency response is not delivered while reset is held.
  assign cpu_resp_valid = rst && vld[MEM_LATENCY-1] && (own[MEM_LATENCY-1] == OWNER_CPU);
  assign dbg_resp_valid = rst && vld[MEM_LATENCY-1] && (own[MEM_LATENCY-1] == OWNER_DBG);
endmodule

// File: rtl/mem_port_arbiter.sv
// CPU-priority arbiter for one single-port BRAM, with a starvation counter
// that forces the debug/loader port through after STARVE_LIMIT lost conflicts.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  mem_port_arbiter_if.slave       cpu,
  mem_port_arbiter_if.slave       dbg,
  output logic                    mem_en,
  output logic [DATA_WIDTH/8-1:0] mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_din,
  input  logic [DATA_WIDTH-1:0]   mem_dout,
  output logic                    dbg_starved
);
  localparam int unsigned   CW    = cnt_width(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  logic          both;
  logic          at_limit;
  logic          grant_cpu;
  logic          grant_dbg;

  always_comb begin
    both        = cpu.req_valid && dbg.req_valid;
    at_limit    = (starve_cnt == LIMIT);
    grant_dbg   = rst && dbg.req_valid && (!cpu.req_valid || at_limit);
    grant_cpu   = rst && cpu.req_valid && !(dbg.req_valid && at_limit);
    dbg_starved = rst && both && at_limit;
  end

  assign cpu.req_ready = grant_cpu;
  assign dbg.req_ready = grant_dbg;

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = '0;
    mem_addr = '0;
    mem_din  = '0;
    if (grant_cpu) begin
      mem_en   = 1'b1;
      mem_we   = cpu.req_be;
      mem_addr = cpu.req_addr;
      mem_din  = cpu.req_wdata;
    end else if (grant_dbg) begin
      mem_en   = 1'b1;
      mem_we   = dbg.req_be;
      mem_addr = dbg.req_addr;
      mem_din  = dbg.req_wdata;
    end
  end

  // Only counts lost conflicts; a lone CPU request while debug is idle leaves it unchanged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant_dbg) begin
      starve_cnt <= '0;
    end else if (both) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  arb_resp_tracker #(
    .MEM_LATENCY (MEM_LATENCY)
  ) u_tracker (
    .clk            (clk),
    .rst            (rst),
    .accept         (grant_cpu || grant_dbg),
    .owner          (grant_dbg ? OWNER_DBG : OWNER_CPU),
    .cpu_resp_valid (cpu.resp_valid),
    .dbg_resp_valid (dbg.resp_valid)
  );

  assign cpu.resp_rdata = mem_dout;
  assign dbg.resp_rdata = mem_dout;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives identical traffic into a latency-1 and a latency-2 arbiter, each with
// its own BRAM model, and checks every cycle against a rule-level reference.
module tb_mem_port_arbiter;
  localparam int AW     = 14;
  localparam int DW     = 32;
  localparam int STARVE = 4;
  localparam int DEPTH  = 1 << AW;
  localparam int NCYC   = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          cpu_v, dbg_v;
  logic [AW-1:0] cpu_a, dbg_a;
  logic [DW-1:0] cpu_w, dbg_w;
  logic [3:0]    cpu_be, dbg_be;

  logic          cpu_rdy [2];
  logic          dbg_rdy [2];
  logic          men     [2];
  logic [3:0]    mwe     [2];
  logic [AW-1:0] maddr   [2];
  logic [DW-1:0] mdin    [2];
  logic          starved [2];
  logic          cpu_rv  [2];
  logic          dbg_rv  [2];
  logic [DW-1:0] cpu_rd  [2];
  logic [DW-1:0] dbg_rd  [2];

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 16) return 32'hDEADBEEF;
    if (i == 48) return 32'h0000_0000;
    return (i * 32'h0101_0101) + 32'h5A00_0000;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = g + 1;
    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cpu_if ();
    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dbg_if ();
    logic [3:0]    we;
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] din, dout, rd1, rd2;
    logic [DW-1:0] ram [0:DEPTH-1];

    assign cpu_if.req_valid = cpu_v;
    assign cpu_if.req_addr  = cpu_a;
    assign cpu_if.req_wdata = cpu_w;
    assign cpu_if.req_be    = cpu_be;
    assign dbg_if.req_valid = dbg_v;
    assign dbg_if.req_addr  = dbg_a;
    assign dbg_if.req_wdata = dbg_w;
    assign dbg_if.req_be    = dbg_be;

    mem_port_arbiter #(
      .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .MEM_LATENCY (LAT), .STARVE_LIMIT (STARVE)
    ) dut (
      .clk (clk), .rst (rst), .cpu (cpu_if), .dbg (dbg_if),
      .mem_en (en), .mem_we (we), .mem_addr (addr), .mem_din (din),
      .mem_dout (dout), .dbg_starved (starved[g])
    );

    initial for (int i = 0; i < DEPTH; i++) ram[i] = init_word(i);

    always @(posedge clk) begin
      if (en) begin
        for (int b = 0; b < 4; b++)
          if (we[b]) ram[addr][b*8 +: 8] <= din[b*8 +: 8];
        rd1 <= ram[addr];
      end
      rd2 <= rd1;
    end
    assign dout = (LAT == 1) ? rd1 : rd2;

    assign cpu_rdy[g] = cpu_if.req_ready;
    assign dbg_rdy[g] = dbg_if.req_ready;
    assign men[g]     = en;
    assign mwe[g]     = we;
    assign maddr[g]   = addr;
    assign mdin[g]    = din;
    assign cpu_rv[g]  = cpu_if.resp_valid;
    assign dbg_rv[g]  = dbg_if.resp_valid;
    assign cpu_rd[g]  = cpu_if.resp_rdata;
    assign dbg_rd[g]  = dbg_if.resp_rdata;
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int m_cnt  = 0;
  logic g_cpu = 1'b0, g_dbg = 1'b0;
  logic [DW-1:0] shadow [0:DEPTH-1];
  bit            ev  [2][NCYC];
  bit            eo  [2][NCYC];
  bit            erd [2][NCYC];
  logic [DW-1:0] ed  [2][NCYC];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    logic st, gd, gc, ecv, edv;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [3:0]    be;
    st = rst && cpu_v && dbg_v && (m_cnt == STARVE);
    gd = rst && dbg_v && (!cpu_v || st);
    gc = rst && cpu_v && !gd;
    a  = gc ? cpu_a  : dbg_a;
    wd = gc ? cpu_w  : dbg_w;
    be = gc ? cpu_be : dbg_be;
    #1;
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("cpu_ready[L%0d]", l), 64'(cpu_rdy[l]), 64'(gc));
      chk($sformatf("dbg_ready[L%0d]", l), 64'(dbg_rdy[l]), 64'(gd));
      chk($sformatf("mem_en[L%0d]", l), 64'(men[l]), 64'(gc || gd));
      chk($sformatf("mem_we[L%0d]", l), 64'(mwe[l]), (gc || gd) ? 64'(be) : 64'd0);
      chk($sformatf("dbg_starved[L%0d]", l), 64'(starved[l]), 64'(st));
      if (gc || gd) begin
        chk($sformatf("mem_addr[L%0d]", l), 64'(maddr[l]), 64'(a));
        chk($sformatf("mem_din[L%0d]", l), 64'(mdin[l]), 64'(wd));
      end
      ecv = rst && ev[l][cyc] && !eo[l][cyc];
      edv = rst && ev[l][cyc] &&  eo[l][cyc];
      chk($sformatf("cpu_resp_valid[L%0d]", l), 64'(cpu_rv[l]), 64'(ecv));
      chk($sformatf("dbg_resp_valid[L%0d]", l), 64'(dbg_rv[l]), 64'(edv));
      if (ecv && erd[l][cyc]) chk($sformatf("cpu_resp_rdata[L%0d]", l), 64'(cpu_rd[l]), 64'(ed[l][cyc]));
      if (edv && erd[l][cyc]) chk($sformatf("dbg_resp_rdata[L%0d]", l), 64'(dbg_rd[l]), 64'(ed[l][cyc]));
    end
    if (!rst) begin
      m_cnt = 0;
      for (int l = 0; l < 2; l++) begin
        ev[l][cyc+1] = 1'b0;
        ev[l][cyc+2] = 1'b0;
      end
    end else begin
      if (gd) m_cnt = 0;
      else if (gc && dbg_v) m_cnt++;
      if (gc || gd) begin
        for (int l = 0; l < 2; l++) begin
          ev[l][cyc+l+1]  = 1'b1;
          eo[l][cyc+l+1]  = gd;
          erd[l][cyc+l+1] = (be == 4'h0);
          ed[l][cyc+l+1]  = shadow[a];
        end
        for (int b = 0; b < 4; b++)
          if (be[b]) shadow[a][b*8 +: 8] = wd[b*8 +: 8];
      end
    end
    g_cpu = gc;
    g_dbg = gd;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_cpu(input logic v, input int a, input logic [DW-1:0] w, input logic [3:0] be);
    cpu_v = v; cpu_a = AW'(a); cpu_w = w; cpu_be = be;
  endtask

  task automatic set_dbg(input logic v, input int a, input logic [DW-1:0] w, input logic [3:0] be);
    dbg_v = v; dbg_a = AW'(a); dbg_w = w; dbg_be = be;
  endtask

  task automatic idle(input int n);
    set_cpu(1'b0, 0, '0, 4'h0);
    set_dbg(1'b0, 0, '0, 4'h0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
    rst = 1'b0;
    set_cpu(1'b1, 5, 32'h1, 4'hF);
    set_dbg(1'b1, 6, 32'h2, 4'h0);
    @(negedge clk);

    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;

    set_cpu(1'b1, 16'h10, '0, 4'h0); set_dbg(1'b0, 0, '0, 4'h0); step();
    idle(3);

    set_dbg(1'b1, 16'h20, 32'h12345678, 4'hF); step();
    set_dbg(1'b0, 0, '0, 4'h0); set_cpu(1'b1, 16'h20, '0, 4'h0); step();
    idle(3);

    set_dbg(1'b1, 16'h21, '0, 4'h0);
    for (int i = 0; i < 15; i++) begin
      set_cpu(1'b1, i, '0, 4'h0);
      step();
    end
    idle(3);

    set_cpu(1'b1, 16'h30, 32'hAABBCCDD, 4'b0010); step();
    set_cpu(1'b1, 16'h30, '0, 4'h0); step();
    idle(3);

    set_dbg(1'b1, 16'h10, '0, 4'h0); step();
    set_dbg(1'b0, 0, '0, 4'h0); rst = 1'b0; step();
    rst = 1'b1; idle(4);

    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin set_cpu(1'b1, 1, '0, 4'h0); set_dbg(1'b0, 0, '0, 4'h0); end
      else            begin set_cpu(1'b0, 0, '0, 4'h0); set_dbg(1'b1, 2, '0, 4'h0); end
      step();
    end
    idle(3);

    for (int n = 0; n < 300; n++) begin
      rst = ($urandom_range(0, 59) != 0);
      if (!(cpu_v && !g_cpu))
        set_cpu($urandom_range(0, 9) < 7, $urandom_range(0, 63), $urandom,
                $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15)));
      if (!(dbg_v && !g_dbg))
        set_dbg($urandom_range(0, 9) < 5, $urandom_range(0, 63), $urandom,
                $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15)));
      step();
    end
    rst = 1'b1;
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
